cell_comm_rx_demux: RTL and testbench
=====================================

# cell_comm_rx_demux

Receive-side decoder for the cell-communication links: consumes one Aurora RX AXI-Stream (CW or CCW), frames and validates the 4-word per-BPM FA packets that the transmit mux merges onto the link, and writes each good packet's BPM index, X/Y/S and clip flags to a FOFB table write port. It also keeps saturating per-cause error counters. One instance sits behind each link's Aurora RX in the user-clock domain, upstream of the FOFB readback table.

## Interface
- MAGIC, 8'hA5, required value of header word [31:24]
- ADC_COUNT, 4, clip-flag bits carried in header [16+:ADC_COUNT]
- FOFB_IDX_WIDTH, 9, BPM index field, header [FOFB_IDX_WIDTH-1:0]
- DATA_WIDTH, 32, X/Y/S word width; fixed at 32
- CRC_TIMEOUT, 4, cycles after tlast to wait for CRC status

Ports (one clock; reset is asynchronous and active-high):
- axisUserClk  in  1  link user clock; all logic on rising edge
- axisUserReset  in  1  asynchronous, active-high reset
- channelUp  in  1  Aurora channel up
- axisRxTvalid / axisRxTlast  in  1 / 1  RX beat valid / last beat; no tready, no backpressure
- axisRxTdata  in  32  RX data
- axisRxCRCvalid / axisRxCRCpass  in  1 / 1  CRC status strobe / result
- clearCounters  in  1  synchronous pulse, zeroes all counters
- wrStrobe  out  1  one-cycle commit pulse
- wrAddr  out  FOFB_IDX_WIDTH  BPM index
- wrX / wrY / wrS  out  DATA_WIDTH each  FA values
- wrClipped  out  ADC_COUNT  clip flags
- goodCount, crcErrCount, headerErrCount, lengthErrCount  out  16 each  saturating counters

## Operation
- Packet: word0 header {MAGIC, clip flags, index}; word1 X; word2 Y; word3 S with tlast. Exactly 4 beats.
- States: S_HDR, S_BODY, S_CRC, S_DROP.
- S_HDR: on valid beat, if [31:24]!=MAGIC then headerErr++. Go S_DROP, or stay S_HDR if tlast is set. If tlast is set with a good magic, lengthErr++ and stay. Otherwise latch index/clip, beat count = 1, go S_BODY.
- S_BODY: latch X/Y/S into shadow registers by beat count.
  - tlast before word3: lengthErr++, go S_HDR.
  - word3 without tlast: lengthErr++, go S_DROP.
  - word3 with tlast: go S_CRC. If CRCvalid is asserted on that same beat, evaluate it immediately.
- S_CRC: wait up to CRC_TIMEOUT cycles for CRCvalid.
  - CRCpass: commit, goodCount++.
  - CRC fail: crcErr++.
  - Timeout: crcErr++.
  - Every case returns to S_HDR.
  - A valid beat arriving in S_CRC counts crcErr++ and is processed as a header in that same cycle.
- S_DROP: discard beats until tlast, then go S_HDR. No counters change.
- channelUp low: return to S_HDR from any state, discard shadow registers, no commit, no counter change.
- Commit: shadow values go to the wr* registers and wrStrobe pulses. The wr* outputs hold their values until the next commit.
- Counters saturate at 16'hFFFF. A clearCounters pulse takes priority over an increment in the same cycle.

## Timing
- Reset: state S_HDR; wrStrobe 0; wrAddr/wrX/wrY/wrS/wrClipped 0; all counters 0.
- Latency: wrStrobe is asserted the cycle after the cycle in which CRCvalid&&CRCpass is sampled. Best case, CRC arrives on the tlast beat: wrStrobe fires 1 cycle after the tlast beat, 4 cycles after the header beat.
- Back-to-back packets: a header is accepted the cycle after tlast when CRC status arrived with tlast. Sustained rate is 1 packet per 4 beats.
- Counter updates are visible the cycle after the deciding event.
- Reset asserted mid-packet clears everything asynchronously. The first beat sampled after deassertion is treated as a header.

## Test plan
- Good packet, header 32'hA5_05_0012 (clip=4'h5, idx=0x12), X=1, Y=-2, S=0x1000, CRC pass on the tlast beat -> wrStrobe 1 cycle later with wrAddr=0x12, wrClipped=4'h5, X/Y/S exact; goodCount=1.
- Same packet with CRCpass=0 delivered 2 cycles after tlast -> no wrStrobe; crcErrCount=1. No CRCvalid at all -> timeout after 4 cycles, crcErrCount=2.
- 3-beat packet (tlast on Y) -> lengthErrCount=1, no commit. 6-beat packet -> lengthErrCount=2, the remaining beats are dropped, and the next good packet commits normally.
- Header 32'h5A000001 followed by 3 beats -> headerErrCount=1, no commit. The following good packet commits with its own index.
- channelUp dropped after word1 -> no commit and no counter change. The next full packet commits correctly.
- Preset 65535 good packets then send one more -> goodCount stays 16'hFFFF. clearCounters coinciding with a good commit -> goodCount reads 0 and wrStrobe still fires.

Source files
------------

// File: rtl/cell_comm_rx_demux.sv
// Receive-side FA packet decoder for one cell-communication link.
// Frames 4-word BPM packets, waits for the Aurora CRC verdict and commits good packets to the FOFB table.
module cell_comm_rx_demux #(
  parameter logic [7:0] MAGIC          = 8'hA5,
  parameter int         ADC_COUNT      = 4,
  parameter int         FOFB_IDX_WIDTH = 9,
  parameter int         DATA_WIDTH     = 32,
  parameter int         CRC_TIMEOUT    = 4
) (
  input  logic                      axisUserClk,
  input  logic                      axisUserReset,
  input  logic                      channelUp,
  input  logic                      axisRxTvalid,
  input  logic                      axisRxTlast,
  input  logic [31:0]               axisRxTdata,
  input  logic                      axisRxCRCvalid,
  input  logic                      axisRxCRCpass,
  input  logic                      clearCounters,
  output logic                      wrStrobe,
  output logic [FOFB_IDX_WIDTH-1:0] wrAddr,
  output logic [DATA_WIDTH-1:0]     wrX,
  output logic [DATA_WIDTH-1:0]     wrY,
  output logic [DATA_WIDTH-1:0]     wrS,
  output logic [ADC_COUNT-1:0]      wrClipped,
  output logic [15:0]               goodCount,
  output logic [15:0]               crcErrCount,
  output logic [15:0]               headerErrCount,
  output logic [15:0]               lengthErrCount
);

  typedef enum logic [1:0] {S_HDR, S_BODY, S_CRC, S_DROP} state_t;

  localparam int TW = (CRC_TIMEOUT > 1) ? $clog2(CRC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CRC_TIMEOUT - 1);

  state_t                    stateReg, stateNext;
  logic [1:0]                beatReg, beatNext;
  logic [TW-1:0]             timerReg, timerNext;
  logic [FOFB_IDX_WIDTH-1:0] idxReg, idxNext;
  logic [ADC_COUNT-1:0]      clipReg, clipNext;
  logic [DATA_WIDTH-1:0]     xReg, xNext, yReg, yNext, sReg, sNext, commitS;
  logic                      commit, takeHdr;
  logic                      incGood, incCrc, incHdr, incLen;
  logic [15:0]               goodCountReg, crcErrCountReg, headerErrCountReg, lengthErrCountReg;

  function automatic logic [15:0] satInc(input logic [15:0] cnt, input logic inc, input logic clr);
    if (clr) return 16'd0;
    if (inc && cnt != 16'hFFFF) return cnt + 16'd1;
    return cnt;
  endfunction

  always_comb begin
    stateNext = stateReg;
    beatNext  = beatReg;
    timerNext = timerReg;
    idxNext   = idxReg;
    clipNext  = clipReg;
    xNext     = xReg;
    yNext     = yReg;
    sNext     = sReg;
    commitS   = sReg;
    commit    = 1'b0;
    takeHdr   = 1'b0;
    incGood   = 1'b0;
    incCrc    = 1'b0;
    incHdr    = 1'b0;
    incLen    = 1'b0;

    case (stateReg)
      S_HDR: takeHdr = axisRxTvalid;
      S_BODY: begin
        if (axisRxTvalid) begin
          case (beatReg)
            2'd1:    xNext = axisRxTdata;
            2'd2:    yNext = axisRxTdata;
            default: sNext = axisRxTdata;
          endcase
          if (beatReg == 2'd3) begin
            if (!axisRxTlast) begin
              incLen    = 1'b1;
              stateNext = S_DROP;
            end else if (axisRxCRCvalid) begin
              // CRC verdict arrived with tlast: S is still on the bus, not yet in sReg.
              commitS   = axisRxTdata;
              commit    = axisRxCRCpass;
              incGood   = axisRxCRCpass;
              incCrc    = !axisRxCRCpass;
              stateNext = S_HDR;
            end else begin
              timerNext = '0;
              stateNext = S_CRC;
            end
          end else if (axisRxTlast) begin
            incLen    = 1'b1;
            stateNext = S_HDR;
          end else begin
            beatNext = beatReg + 2'd1;
          end
        end
      end
      S_CRC: begin
        takeHdr = axisRxTvalid;
        if (axisRxCRCvalid) begin
          commit    = axisRxCRCpass;
          incGood   = axisRxCRCpass;
          incCrc    = !axisRxCRCpass;
          stateNext = S_HDR;
        end else if (axisRxTvalid || timerReg == TIMER_LAST) begin
          incCrc    = 1'b1;
          stateNext = S_HDR;
        end else begin
          timerNext = timerReg + 1'b1;
        end
      end
      default: if (axisRxTvalid && axisRxTlast) stateNext = S_HDR;
    endcase

    // Header decode is shared by S_HDR and a beat that cuts a CRC wait short.
    if (takeHdr) begin
      if (axisRxTdata[31:24] != MAGIC) begin
        incHdr    = 1'b1;
        stateNext = axisRxTlast ? S_HDR : S_DROP;
      end else if (axisRxTlast) begin
        incLen    = 1'b1;
        stateNext = S_HDR;
      end else begin
        idxNext   = axisRxTdata[FOFB_IDX_WIDTH-1:0];
        clipNext  = axisRxTdata[16 +: ADC_COUNT];
        beatNext  = 2'd1;
        stateNext = S_BODY;
      end
    end

    if (!channelUp) begin
      stateNext = S_HDR;
      beatNext  = 2'd0;
      timerNext = '0;
      idxNext   = '0;
      clipNext  = '0;
      xNext     = '0;
      yNext     = '0;
      sNext     = '0;
      commit    = 1'b0;
      incGood   = 1'b0;
      incCrc    = 1'b0;
      incHdr    = 1'b0;
      incLen    = 1'b0;
    end
  end

  always_ff @(posedge axisUserClk or posedge axisUserReset) begin
    if (axisUserReset) begin
      stateReg          <= S_HDR;
      beatReg           <= 2'd0;
      timerReg          <= '0;
      idxReg            <= '0;
      clipReg           <= '0;
      xReg              <= '0;
      yReg              <= '0;
      sReg              <= '0;
      wrStrobe          <= 1'b0;
      wrAddr            <= '0;
      wrX               <= '0;
      wrY               <= '0;
      wrS               <= '0;
      wrClipped         <= '0;
      goodCountReg      <= 16'd0;
      crcErrCountReg    <= 16'd0;
      headerErrCountReg <= 16'd0;
      lengthErrCountReg <= 16'd0;
    end else begin
      stateReg          <= stateNext;
      beatReg           <= beatNext;
      timerReg          <= timerNext;
      idxReg            <= idxNext;
      clipReg           <= clipNext;
      xReg              <= xNext;
      yReg              <= yNext;
      sReg              <= sNext;
      wrStrobe          <= commit;
      if (commit) begin
        wrAddr    <= idxReg;
        wrX       <= xReg;
        wrY       <= yReg;
        wrS       <= commitS;
        wrClipped <= clipReg;
      end
      goodCountReg      <= satInc(goodCountReg, incGood, clearCounters);
      crcErrCountReg    <= satInc(crcErrCountReg, incCrc, clearCounters);
      headerErrCountReg <= satInc(headerErrCountReg, incHdr, clearCounters);
      lengthErrCountReg <= satInc(lengthErrCountReg, incLen, clearCounters);
    end
  end

  assign goodCount      = goodCountReg;
  assign crcErrCount    = crcErrCountReg;
  assign headerErrCount = headerErrCountReg;
  assign lengthErrCount = lengthErrCountReg;

endmodule

// File: tb/tb_cell_comm_rx_demux.sv
// Bench for cell_comm_rx_demux: directed packets from the test plan plus randomized packets
// scored against a packet-level outcome model.
module tb_cell_comm_rx_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        channelUp, tvalid, tlast, crcV, crcP, clr;
  logic [31:0] tdata;
  logic        wrStrobe;
  logic [8:0]  wrAddr;
  logic [31:0] wrX, wrY, wrS;
  logic [3:0]  wrClipped;
  logic [15:0] goodCount, crcErrCount, headerErrCount, lengthErrCount;

  cell_comm_rx_demux dut (
    .axisUserClk(clk), .axisUserReset(rst), .channelUp(channelUp),
    .axisRxTvalid(tvalid), .axisRxTlast(tlast), .axisRxTdata(tdata),
    .axisRxCRCvalid(crcV), .axisRxCRCpass(crcP), .clearCounters(clr),
    .wrStrobe(wrStrobe), .wrAddr(wrAddr), .wrX(wrX), .wrY(wrY), .wrS(wrS),
    .wrClipped(wrClipped), .goodCount(goodCount), .crcErrCount(crcErrCount),
    .headerErrCount(headerErrCount), .lengthErrCount(lengthErrCount)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cycleCnt = 0, strobeCount = 0, lastStrobeCycle = -1, tlastCycle = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;
  always @(negedge clk) if (wrStrobe === 1'b1) begin
    strobeCount     <= strobeCount + 1;
    lastStrobeCycle <= cycleCnt;
  end

  // Reference expectations
  int expGood, expCrc, expHdr, expLen, expStrobes, expStrobeCycle;
  logic [31:0] expAddr, expX, expY, expS, expClip;

  logic [31:0] pkt [0:7];
  int pktLen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    tvalid = 0; tlast = 0; tdata = 0; crcV = 0; crcP = 0; clr = 0; channelUp = 1;
    repeat (n - 1) @(negedge clk);
  endtask

  // crcDelay: 0 = with tlast, k>0 = k cycles after tlast, <0 = never. dropAt: beat index where channelUp falls.
  task automatic sendPkt(input int crcDelay, input bit crcPass, input int dropAt, input bit clrOnLast);
    for (int i = 0; i < pktLen; i++) begin
      @(negedge clk);
      if (i == dropAt) begin
        tvalid = 0; tlast = 0; channelUp = 0;
        @(negedge clk);
        channelUp = 1;
        return;
      end
      tvalid = 1; tdata = pkt[i]; tlast = (i == pktLen - 1);
      crcV = tlast && (crcDelay == 0);
      crcP = crcV && crcPass;
      clr  = tlast && clrOnLast;
      if (tlast) tlastCycle = cycleCnt;
    end
    if (crcDelay != 0) begin
      @(negedge clk);
      tvalid = 0; tlast = 0; clr = 0;
      if (crcDelay > 0) begin
        repeat (crcDelay - 1) @(negedge clk);
        crcV = 1; crcP = crcPass;
      end
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Outcome of one whole packet, decided from its shape rather than beat by beat.
  task automatic modelPkt(input int crcDelay, input bit crcPass, input bit dropped, input bit clrOnLast);
    logic [31:0] h;
    h = pkt[0];
    if (clrOnLast) begin
      expGood = 0; expCrc = 0; expHdr = 0; expLen = 0;
    end
    if (dropped) return;
    if (h[31:24] != 8'hA5) begin
      if (!clrOnLast) expHdr = sat(expHdr);
    end else if (pktLen != 4) begin
      if (!clrOnLast) expLen = sat(expLen);
    end else if (crcDelay < 0 || crcDelay > 4 || !crcPass) begin
      if (!clrOnLast) expCrc = sat(expCrc);
    end else begin
      if (!clrOnLast) expGood = sat(expGood);
      expStrobes++;
      expStrobeCycle = tlastCycle + 1 + crcDelay;
      expAddr = {23'd0, h[8:0]};
      expClip = {28'd0, h[19:16]};
      expX = pkt[1]; expY = pkt[2]; expS = pkt[3];
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".goodCount"}, {16'd0, goodCount}, 32'(expGood));
    check({tag, ".crcErrCount"}, {16'd0, crcErrCount}, 32'(expCrc));
    check({tag, ".headerErrCount"}, {16'd0, headerErrCount}, 32'(expHdr));
    check({tag, ".lengthErrCount"}, {16'd0, lengthErrCount}, 32'(expLen));
    check({tag, ".strobes"}, 32'(strobeCount), 32'(expStrobes));
    check({tag, ".strobeCycle"}, 32'(lastStrobeCycle), 32'(expStrobeCycle));
    check({tag, ".wrAddr"}, {23'd0, wrAddr}, expAddr);
    check({tag, ".wrClipped"}, {28'd0, wrClipped}, expClip);
    check({tag, ".wrX"}, wrX, expX);
    check({tag, ".wrY"}, wrY, expY);
    check({tag, ".wrS"}, wrS, expS);
  endtask

  task automatic runPkt(input string tag, input int crcDelay, input bit crcPass, input int dropAt, input bit clrOnLast);
    sendPkt(crcDelay, crcPass, dropAt, clrOnLast);
    modelPkt(crcDelay, crcPass, dropAt >= 0, clrOnLast);
    idle(10);
    checkAll(tag);
    $display("pkt %s len=%0d hdr=%08h crcDelay=%0d pass=%0d good=%0d crc=%0d hdrErr=%0d lenErr=%0d",
             tag, pktLen, pkt[0], crcDelay, crcPass, goodCount, crcErrCount, headerErrCount, lengthErrCount);
  endtask

  task automatic randPayload(input logic [8:0] idx, input logic [3:0] clip);
    logic [31:0] r;
    r = $urandom();
    pkt[0] = {8'hA5, r[23:20], clip, r[15:9], idx};
    for (int i = 1; i < 8; i++) pkt[i] = $urandom();
    pktLen = 4;
  endtask

  initial begin
    int kind, d, drop;
    bit pass;
    logic [31:0] r;

    rst = 1; channelUp = 1; tvalid = 0; tlast = 0; tdata = 0; crcV = 0; crcP = 0; clr = 0;
    expGood = 0; expCrc = 0; expHdr = 0; expLen = 0; expStrobes = 0; expStrobeCycle = -1;
    expAddr = 0; expX = 0; expY = 0; expS = 0; expClip = 0;
    repeat (3) @(negedge clk);
    check("reset.wrStrobe", {31'd0, wrStrobe}, 32'd0);
    checkAll("reset");
    rst = 0;
    idle(2);

    // Test-plan good packet
    pkt[0] = 32'hA505_0012; pkt[1] = 32'd1; pkt[2] = 32'hFFFF_FFFE; pkt[3] = 32'h1000; pktLen = 4;
    runPkt("good", 0, 1, -1, 0);
    runPkt("crcFail", 2, 0, -1, 0);
    runPkt("crcTimeout", -1, 1, -1, 0);

    pktLen = 3;
    runPkt("short3", -1, 1, -1, 0);
    pktLen = 6; pkt[4] = 32'hA5FF_FFFF; pkt[5] = 32'h1234_5678;
    runPkt("long6", -1, 1, -1, 0);
    randPayload(9'h0AB, 4'h3);
    runPkt("afterLong", 0, 1, -1, 0);

    pkt[0] = 32'h5A00_0001; pktLen = 4;
    runPkt("badMagic", 0, 1, -1, 0);
    randPayload(9'h155, 4'hA);
    runPkt("afterBadMagic", 1, 1, -1, 0);

    randPayload(9'h077, 4'hF);
    runPkt("chanDrop", 0, 1, 2, 0);
    randPayload(9'h1C0, 4'h6);
    runPkt("afterChanDrop", 3, 1, -1, 0);

    // Two packets with no gap: second header follows the first tlast directly
    randPayload(9'h011, 4'h1);
    sendPkt(0, 1, -1, 0);
    modelPkt(0, 1, 0, 0);
    randPayload(9'h022, 4'h2);
    runPkt("backToBack", 0, 1, -1, 0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom();
      randPayload(r[8:0], r[12:9]);
      kind = $urandom_range(0, 5);
      d = -1; pass = 1; drop = -1;
      case (kind)
        0: d = $urandom_range(0, 4);
        1: begin d = $urandom_range(0, 4); pass = 0; end
        2: d = ($urandom_range(0, 1) == 0) ? -1 : 5;
        3: pktLen = $urandom_range(1, 3);
        4: pktLen = $urandom_range(5, 8);
        default: begin
          pkt[0][31:24] = 8'hA5 ^ 8'($urandom_range(1, 255));
          pktLen = $urandom_range(1, 6);
        end
      endcase
      runPkt($sformatf("rand%0d", n), d, pass, drop, 0);
    end

    // Asynchronous reset in the middle of a packet
    randPayload(9'h1FF, 4'hC);
    @(negedge clk); tvalid = 1; tdata = pkt[0]; tlast = 0;
    @(negedge clk); tdata = pkt[1];
    #1 rst = 1;
    #1;
    check("asyncRst.goodCount", {16'd0, goodCount}, 32'd0);
    check("asyncRst.crcErrCount", {16'd0, crcErrCount}, 32'd0);
    check("asyncRst.wrAddr", {23'd0, wrAddr}, 32'd0);
    check("asyncRst.wrX", wrX, 32'd0);
    @(negedge clk); tvalid = 0; rst = 0;
    expGood = 0; expCrc = 0; expHdr = 0; expLen = 0;
    expAddr = 0; expX = 0; expY = 0; expS = 0; expClip = 0;
    randPayload(9'h0C3, 4'h9);
    runPkt("afterAsyncRst", 0, 1, -1, 0);

    // Saturation: deposit near the top instead of sending 65535 packets
    @(negedge clk);
    dut.goodCountReg = 16'hFFFE;
    expGood = 65534;
    randPayload(9'h101, 4'h4);
    runPkt("satReach", 0, 1, -1, 0);
    randPayload(9'h102, 4'h8);
    runPkt("satHold", 2, 1, -1, 0);
    randPayload(9'h103, 4'hB);
    runPkt("clearWithCommit", 0, 1, -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
